// File: rtl/branch_history_tracker_pkg.sv
// Shared constants, FSM encoding and in-flight entry layout for the branch history tracker.
package branch_history_tracker_pkg;

  localparam int unsigned GHR_W = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MCNT_W = 8;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_PRED = 1'b1
  } bht_state_t;

  typedef struct packed {
    logic [GHR_W-1:0] snapshot;
    logic             pred;
  } bq_entry_t;

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-order queue of predicted, unresolved branches; clear empties it in one edge.
module branch_inflight_fifo
  import branch_history_tracker_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  bq_entry_t push_entry,
  input  logic      pop,
  input  logic      clear,
  output logic      full,
  output logic      empty,
  output bq_entry_t head
);

  bq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/branch_history_tracker.sv
// Speculative global history owner: PHT lookup sequencing, in-flight tracking and mispredict repair.
module branch_history_tracker
  import branch_history_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             resolve_ready,
  output logic [GHR_W-1:0] ghr_out,
  output logic             pht_update,
  output logic             pht_taken,
  input  logic             pht_predicted,
  output logic             flush,
  output logic [7:0]       mispredict_count
);

  bht_state_t        state;
  bht_state_t        state_d;
  logic [GHR_W-1:0]  spec_ghr;
  logic [GHR_W-1:0]  spec_ghr_d;
  logic              fetch_fire;
  logic              resolve_fire;
  logic              mispredict;
  logic              q_push;
  logic              q_full;
  logic              q_empty;
  bq_entry_t         q_head;
  bq_entry_t         q_push_entry;
  logic              flush_q;
  logic [MCNT_W-1:0] mcount_q;

  branch_inflight_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (resolve_fire),
    .clear      (mispredict),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head)
  );

  // State, history, flush pulse and saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      spec_ghr <= '0;
      flush_q  <= 1'b0;
      mcount_q <= '0;
    end else begin
      state    <= state_d;
      spec_ghr <= spec_ghr_d;
      flush_q  <= mispredict;
      if (mispredict && (mcount_q != {MCNT_W{1'b1}})) mcount_q <= mcount_q + MCNT_W'(1);
    end
  end

  // Handshakes, next state, history update and PHT-facing outputs; resolve wins over fetch.
  always_comb begin
    state_d       = state;
    spec_ghr_d    = spec_ghr;
    resolve_ready = (state == IDLE) && !q_empty;
    resolve_fire  = reset && resolve_valid && resolve_ready;
    fetch_ready   = (state == IDLE) && !q_full && !(resolve_valid && resolve_ready);
    fetch_fire    = reset && fetch_valid && fetch_ready;
    mispredict    = resolve_fire && (resolve_taken != q_head.pred);
    q_push        = reset && (state == WAIT_PRED);
    q_push_entry  = '{snapshot: spec_ghr, pred: pht_predicted};
    pred_valid    = q_push;
    pred_taken    = q_push && pht_predicted;
    pht_update    = resolve_fire;
    pht_taken     = resolve_fire && resolve_taken;
    ghr_out       = resolve_fire ? q_head.snapshot : spec_ghr;

    case (state)
      IDLE: begin
        if (fetch_fire) state_d = WAIT_PRED;
      end
      WAIT_PRED: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (q_push) begin
      spec_ghr_d = {spec_ghr[GHR_W-2:0], pht_predicted};
    end else if (mispredict) begin
      spec_ghr_d = {q_head.snapshot[GHR_W-2:0], resolve_taken};
    end
  end

  assign flush            = flush_q;
  assign mispredict_count = mcount_q;

endmodule

// File: doc/branch_history_tracker.md
Name: branch_history_tracker

Overview:
Front-end companion to the 8-entry Pattern_History_Table. It owns the speculative 3-bit global history and presents it to the PHT for lookups. It keeps an in-order queue of in-flight predicted branches, each with its GHR snapshot and predicted bit. When the execute stage resolves a branch, it issues the PHT update (index = snapshot, taken = actual outcome) and, on mispredict, repairs the history and signals a flush.

Parameters:
GHR_W, 3, history width; PHT index width (PHT has 2**GHR_W entries)
DEPTH, 4, maximum in-flight unresolved branches
PTR_W, 2, queue pointer width, log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
fetch_valid  input  1  fetch stage requests a prediction for a branch
fetch_ready  output  1  request accepted when fetch_valid & fetch_ready
pred_valid  output  1  one-cycle pulse: prediction result available
pred_taken  output  1  predicted direction, valid with pred_valid
resolve_valid  input  1  execute stage resolves the oldest in-flight branch
resolve_taken  input  1  actual outcome, valid with resolve_valid
resolve_ready  output  1  resolution accepted when resolve_valid & resolve_ready
ghr_out  output  GHR_W  index to PHT GHR input
pht_update  output  1  PHT update strobe
pht_taken  output  1  PHT taken input
pht_predicted  input  1  PHT predicted output (registered inside PHT)
flush  output  1  one-cycle mispredict pulse to fetch/decode
mispredict_count  output  8  saturating mispredict counter

Behaviour:
- Reset (reset==0 at a clk edge):
  - spec_ghr=0; queue empty (count=0); state=IDLE; mispredict_count=0.
  - pred_valid=0, pred_taken=0, flush=0, pht_update=0, pht_taken=0.
- States:
  - IDLE: normal operation.
  - WAIT_PRED: the cycle after a lookup is accepted; the PHT result is being read.
- ghr_out (combinational):
  - Equals the head entry snapshot when pht_update=1.
  - Equals spec_ghr otherwise.
- Handshakes:
  - resolve_ready = (state==IDLE) & (count!=0).
  - fetch_ready = (state==IDLE) & (count!=DEPTH) & ~(resolve_valid & resolve_ready).
  - Resolve has priority over fetch in the same cycle. Only one of the two is accepted per cycle.
- Lookup, fetch accepted in cycle t:
  - pht_update=0 in t, so the PHT latches predicted from PHT[spec_ghr] at the end of t.
  - State goes to WAIT_PRED.
- WAIT_PRED, cycle t+1:
  - pred_valid=1, pred_taken=pht_predicted.
  - Push {snapshot=spec_ghr, pred=pht_predicted} at the tail.
  - spec_ghr <= {spec_ghr[GHR_W-2:0], pht_predicted}.
  - Return to IDLE. Lookup latency is 1 cycle; throughput is one branch per 2 cycles.
- Resolve accepted:
  - Same cycle (combinational): pht_update=1, pht_taken=resolve_taken, ghr_out=head.snapshot.
  - At the edge: pop the head.
- Correct prediction (resolve_taken==head.pred):
  - Nothing further happens.
- Mispredict (resolve_taken!=head.pred), in addition to the pop:
  - At the edge, the whole queue is cleared (count=0, pointers=0).
  - spec_ghr <= {head.snapshot[GHR_W-2:0], resolve_taken}.
  - flush pulses 1 in the following cycle.
  - mispredict_count increments, saturating at 255.
- Boundaries:
  - Pointer wrap modulo DEPTH.
  - Full blocks fetch. Empty blocks resolve.
  - resolve_valid held while not ready is legal; the source keeps its data stable.
  - Reset mid-WAIT_PRED discards the pending prediction with no push and no pred_valid.
  - Flush and pred_valid never coincide, since resolve is blocked in WAIT_PRED.
- Widths: history shift drops the MSB; no arithmetic beyond the count and pointer increments.

Decomposition:
- Shared package holds:
  - GHR_W and DEPTH constants.
  - State encoding (IDLE=0, WAIT_PRED=1).
  - Queue entry struct {snapshot[GHR_W-1:0], pred}.
- One sub-module, branch_inflight_fifo:
  - Synchronous push/pop FIFO with a flush clear.
  - Outputs full, empty and head entry.
- The top holds the FSM, spec_ghr, output muxing and the counter.

Test Plan:
- Reset, idle: hold reset=0 two cycles, release. Require:
  - fetch_ready=1, resolve_ready=0, ghr_out=0, all pulses 0, mispredict_count=0.
- Single lookup: PHT model returns 1 at index 0; fetch once. Require:
  - pred_valid at t+1 with pred_taken=1.
  - ghr_out becomes 3'b001.
  - count=1.
- Fill/full: four lookups returning 1,0,1,1. Require:
  - fetch_ready=0 after the 4th push.
  - spec_ghr=3'b011.
  - Snapshots queued in order: 000, 001, 010, 101.
- Correct resolve: resolve_taken=1 on the head (pred=1, snap 000). Require:
  - Same cycle: pht_update=1, ghr_out=000, pht_taken=1.
  - No flush; count 4 to 3; fetch_ready=1 again.
- Mispredict: head pred=0 (snap 001), resolve_taken=1. Require:
  - pht_update with ghr_out=001.
  - Next cycle flush=1, queue empty, spec_ghr=3'b011, mispredict_count=1.
- Same-cycle fetch and resolve with a non-empty queue. Require:
  - Resolve accepted, fetch_ready=0.
  - Fetch accepted the next cycle.
  - Reset asserted in WAIT_PRED yields no pred_valid and count=0.
